conv_stream_receiver: RTL and testbench

- Consumer end of the convolution test-stimulus interface.
- Accepts 64-bit data words over a valid/ready handshake and keeps a 4-deep sliding window of the most recent words.
- For every accepted word, computes the dot product of the window with the 4-entry kernel, one multiply per cycle.
- Presents the 128-bit result on a second valid/ready output handshake to the result checker, which pulses next_test on the stimulus side.

---
 rtl/conv_stream_receiver.sv | 130 +++++++++++++
 tb/tb_conv_stream_receiver.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_stream_receiver.sv
// conv_stream_receiver: consumer end of the convolution stimulus interface.
// Keeps a TAPS-deep sliding window of accepted words and, for every word,
// forms the dot product of the window with a kernel snapshot, one multiply
// per cycle, then offers the RW-bit result on a valid/ready output.
//
// Ports:
//   clk, rstn    clock, asynchronous active-low reset
//   in_valid     stimulus word valid
//   in_ready     receiver can accept a word
//   in_data      stimulus word (DW bits)
//   kernel       kernel entries [0..TAPS-1]
//   res_valid    result available
//   res_ready    downstream accepts result
//   result       dot-product result (RW bits, truncated sum)
//   window_full  at least TAPS words accepted since reset
//   word_count   accepted words, wraps at 256

package Conv;
  localparam int unsigned DW   = 64;
  localparam int unsigned TAPS = 4;
  typedef logic [TAPS-1:0][DW-1:0] data_vector;
endpackage

module conv_stream_receiver #(
  parameter int unsigned DW   = Conv::DW,
  parameter int unsigned TAPS = Conv::TAPS,
  parameter int unsigned RW   = 128
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_data,
  input  Conv::data_vector     kernel,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [RW-1:0]        result,
  output logic                 window_full,
  output logic [7:0]           word_count
);

  localparam int unsigned SW = $clog2(TAPS);
  localparam int unsigned PW = 2 * DW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_e;

  state_e                   state_q;
  logic [TAPS-1:0][DW-1:0]  window_q;
  logic [TAPS-1:0][DW-1:0]  kshadow_q;
  logic [RW-1:0]            acc_q;
  logic [RW-1:0]            acc_d;
  logic [SW-1:0]            step_q;
  logic [PW-1:0]            prod_c;
  logic                     in_ready_q;
  logic                     res_valid_q;
  logic [RW-1:0]            result_q;
  logic                     window_full_q;
  logic [7:0]               word_count_q;

  // One tap product per CALC cycle; full-width unsigned product, modulo-RW sum.
  assign prod_c = PW'(window_q[step_q]) * PW'(kshadow_q[step_q]);
  assign acc_d  = acc_q + RW'(prod_c);

  // Handshake FSM, window shift, kernel snapshot and accumulation.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      window_q      <= '0;
      kshadow_q     <= '0;
      acc_q         <= '0;
      step_q        <= '0;
      in_ready_q    <= 1'b1;
      res_valid_q   <= 1'b0;
      result_q      <= '0;
      window_full_q <= 1'b0;
      word_count_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            // Newest word enters tap 0; oldest falls off the top.
            window_q     <= {window_q[TAPS-2:0], in_data};
            kshadow_q    <= kernel;
            acc_q        <= '0;
            step_q       <= '0;
            word_count_q <= word_count_q + 8'd1;
            // Sticky: a later wrap of word_count must not clear it.
            if (word_count_q == 8'(TAPS - 1)) begin
              window_full_q <= 1'b1;
            end
            in_ready_q   <= 1'b0;
            state_q      <= CALC;
          end
        end
        CALC: begin
          acc_q  <= acc_d;
          step_q <= step_q + SW'(1);
          if (step_q == SW'(TAPS - 1)) begin
            result_q    <= acc_d;
            res_valid_q <= 1'b1;
            state_q     <= OUT;
          end
        end
        OUT: begin
          // in_ready returns only after the result leaves, so no word is
          // accepted on the same edge as the result transfer.
          if (res_ready) begin
            res_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign res_valid   = res_valid_q;
  assign result      = result_q;
  assign window_full = window_full_q;
  assign word_count  = word_count_q;

endmodule

// File: tb/tb_conv_stream_receiver.sv
module tb_conv_stream_receiver;

  localparam int unsigned DW   = 64;
  localparam int unsigned TAPS = 4;
  localparam int unsigned RW   = 128;

  logic             clk;
  logic             rstn;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  Conv::data_vector kernel;
  logic             res_valid;
  logic             res_ready;
  logic [RW-1:0]    result;
  logic             window_full;
  logic [7:0]       word_count;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_wc;

  conv_stream_receiver #(.DW(DW), .TAPS(TAPS), .RW(RW)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .kernel      (kernel),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .window_full (window_full),
    .word_count  (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    res_ready = 1'b0;
    exp_wc    = 8'd0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_kernel(input logic [DW-1:0] k0, input logic [DW-1:0] k1,
                            input logic [DW-1:0] k2, input logic [DW-1:0] k3);
    kernel[0] = k0;
    kernel[1] = k1;
    kernel[2] = k2;
    kernel[3] = k3;
  endtask

  // Offer a word from a negedge; returns at the negedge after the accepting edge.
  task automatic send_word(input logic [DW-1:0] w, output bit ok);
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      exp_wc = exp_wc + 8'd1;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Counts negedges (from the one after the accept edge) until res_valid; -1 on timeout.
  task automatic wait_res(output int cyc);
    cyc = -1;
    for (int i = 0; i < 20; i++) begin
      if (res_valid) begin
        cyc = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks += 5;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
    if (result !== '0) begin failures++; $display("FAIL reset_result: got %0h expected 0", result); end
    if (window_full !== 1'b0) begin failures++; $display("FAIL reset_window_full: got %b expected 0", window_full); end
    if (word_count !== 8'd0) begin failures++; $display("FAIL reset_word_count: got %0d expected 0", word_count); end
  endtask

  task automatic test_stream();
    logic [RW-1:0] exp_res [5];
    bit ok;
    int cyc;
    exp_res = '{128'd5, 128'd16, 128'd34, 128'd60, 128'd70};
    set_kernel(64'd1, 64'd2, 64'd3, 64'd4);
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_word(64'(5 + i), ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL stream_accept[%0d]: in_ready never seen", i); end
      wait_res(cyc);
      checks += 3;
      if (cyc != 4) begin failures++; $display("FAIL stream_latency[%0d]: got %0d expected 4", i, cyc); end
      if (result !== exp_res[i]) begin failures++; $display("FAIL stream_result[%0d]: got %0d expected %0d", i, result, exp_res[i]); end
      if (window_full !== (i >= 3)) begin failures++; $display("FAIL stream_window_full[%0d]: got %b expected %b", i, window_full, (i >= 3)); end
      @(negedge clk);
      checks += 2;
      if (res_valid !== 1'b0) begin failures++; $display("FAIL stream_res_drop[%0d]: got %b expected 0", i, res_valid); end
      if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready[%0d]: got %b expected 1", i, in_ready); end
    end
    checks++;
    if (word_count !== 8'd5) begin failures++; $display("FAIL stream_word_count: got %0d expected 5", word_count); end
  endtask

  task automatic test_overflow();
    bit ok;
    int cyc;
    logic [RW-1:0] exp_r;
    exp_r = {64'hFFFF_FFFF_FFFF_FFF8, 64'h0000_0000_0000_0004};
    set_kernel('1, '1, '1, '1);
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_word(64'hFFFF_FFFF_FFFF_FFFF, ok);
      wait_res(cyc);
      if (i < 3) @(negedge clk);
    end
    checks++;
    if (result !== exp_r) begin failures++; $display("FAIL overflow_result: got %h expected %h", result, exp_r); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit ok;
    int cyc;
    do_reset();
    set_kernel(64'd1, 64'd2, 64'd3, 64'd4);
    res_ready = 1'b0;
    send_word(64'd10, ok);
    wait_res(cyc);
    checks += 2;
    if (cyc < 0) begin failures++; $display("FAIL bp_timeout: res_valid never seen"); end
    if (result !== 128'd10) begin failures++; $display("FAIL bp_result: got %0d expected 10", result); end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 64'(i * 17 + 3);
      @(negedge clk);
      checks += 3;
      if (res_valid !== 1'b1) begin failures++; $display("FAIL bp_res_valid[%0d]: got %b expected 1", i, res_valid); end
      if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); end
      if (result !== 128'd10) begin failures++; $display("FAIL bp_result_hold[%0d]: got %0d expected 10", i, result); end
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks += 3;
    if (res_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid: got %b expected 0", res_valid); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
    if (word_count !== exp_wc) begin failures++; $display("FAIL bp_word_count: got %0d expected %0d", word_count, exp_wc); end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_kernel_change();
    bit ok;
    int cyc;
    do_reset();
    set_kernel(64'd1, 64'd2, 64'd3, 64'd4);
    res_ready = 1'b1;
    send_word(64'd5, ok);
    set_kernel(64'd9, 64'd9, 64'd9, 64'd9);
    wait_res(cyc);
    checks++;
    if (result !== 128'd5) begin failures++; $display("FAIL kernel_change_result: got %0d expected 5", result); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_calc();
    bit ok;
    int cyc;
    do_reset();
    set_kernel(64'd7, 64'd7, 64'd7, 64'd7);
    res_ready = 1'b1;
    send_word(64'd11, ok);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    checks += 5;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL midreset_in_ready: got %b expected 1", in_ready); end
    if (res_valid !== 1'b0) begin failures++; $display("FAIL midreset_res_valid: got %b expected 0", res_valid); end
    if (result !== '0) begin failures++; $display("FAIL midreset_result: got %0h expected 0", result); end
    if (window_full !== 1'b0) begin failures++; $display("FAIL midreset_window_full: got %b expected 0", window_full); end
    if (word_count !== 8'd0) begin failures++; $display("FAIL midreset_word_count: got %0d expected 0", word_count); end
    exp_wc = 8'd0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    set_kernel(64'd1, 64'd2, 64'd3, 64'd4);
    send_word(64'd3, ok);
    wait_res(cyc);
    checks++;
    if (result !== 128'd3) begin failures++; $display("FAIL midreset_first_result: got %0d expected 3", result); end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    bit ok;
    int cyc;
    int lost;
    do_reset();
    set_kernel(64'd1, 64'd1, 64'd1, 64'd1);
    res_ready = 1'b1;
    lost = 0;
    for (int i = 0; i < 256; i++) begin
      send_word(64'(i), ok);
      wait_res(cyc);
      if (!ok || cyc < 0) lost++;
    end
    @(negedge clk);
    checks += 3;
    if (lost != 0) begin failures++; $display("FAIL wrap_transfers: got %0d lost expected 0", lost); end
    if (word_count !== 8'd0) begin failures++; $display("FAIL wrap_word_count: got %0d expected 0", word_count); end
    if (window_full !== 1'b1) begin failures++; $display("FAIL wrap_window_full: got %b expected 1", window_full); end
  endtask

  initial begin
    set_kernel('0, '0, '0, '0);
    test_reset();
    test_stream();
    test_overflow();
    test_backpressure();
    test_kernel_change();
    test_reset_mid_calc();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
